// File: rtl/sram_like_arbiter.sv
// Purpose : share one SRAM-like memory port between the IFU (inst) and MEM-stage (data) ports.
// Latency : 0 cycles both ways; grant, addr_ok, data_ok and rdata are combinational.
// Backpressure: mem_req drops when the tracking FIFO is full; the loser holds req until addr_ok.
//
// Ports
//   clk, resetn                    clock, synchronous active-low reset
//   inst_sram_* / data_sram_*      master ports: req, wr, size, addr, wstrb, wdata in;
//                                  addr_ok, data_ok, rdata out
//   mem_*                          downstream port: req, wr, size, addr, wstrb, wdata out;
//                                  addr_ok, data_ok, rdata in
//   err_orphan_resp                sticky flag: a response arrived with nothing outstanding
module sram_like_arbiter #(
    parameter int OUTSTANDING  = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        err_orphan_resp
);

    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // Tracking FIFO: one owner bit per accepted request (0 = inst, 1 = data).
    logic [OUTSTANDING-1:0] r_owner;
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [CW-1:0]          r_count;

    logic          r_lock_vld;
    logic          r_lock_owner;
    logic [SW-1:0] r_starve;
    logic          r_err;

    logic w_empty;
    logic w_full;
    logic w_grant_data;
    logic w_req_sel;
    logic w_mem_req;
    logic w_push;
    logic w_pop;
    logic w_head;
    logic w_starved;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(OUTSTANDING));
    assign w_head    = r_owner[r_rptr];
    assign w_starved = (r_starve == SW'(STARVE_LIMIT));

    // A request left hanging without addr_ok pins the grant, so the downstream
    // keeps seeing the same fields until it accepts them.
    always_comb begin
        w_grant_data = 1'b0;
        if (r_lock_vld)
            w_grant_data = r_lock_owner;
        else if (inst_sram_req && w_starved)
            w_grant_data = 1'b0;
        else if (data_sram_req)
            w_grant_data = 1'b1;
        else
            w_grant_data = 1'b0;
    end

    assign w_req_sel = w_grant_data ? data_sram_req : inst_sram_req;
    // Full blocks issue even when a pop lands in the same cycle; this keeps the
    // issue path free of the mem_data_ok input.
    assign w_mem_req = resetn & w_req_sel & ~w_full;
    assign w_push    = w_mem_req & mem_addr_ok;
    assign w_pop     = resetn & mem_data_ok & ~w_empty;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_owner      <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_lock_vld   <= 1'b0;
            r_lock_owner <= 1'b0;
            r_starve     <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_push) begin
                r_owner[r_wptr] <= w_grant_data;
                r_wptr          <= r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_mem_req) begin
                r_lock_vld   <= ~mem_addr_ok;
                r_lock_owner <= w_grant_data;
            end

            // Only cycles where data actually drives the port count against inst;
            // full-FIFO stall cycles leave the counter alone.
            if (w_push && !w_grant_data)
                r_starve <= '0;
            else if (inst_sram_req && w_grant_data && w_mem_req && !w_starved)
                r_starve <= r_starve + 1'b1;

            if (mem_data_ok && w_empty)
                r_err <= 1'b1;
        end
    end

    assign mem_req   = w_mem_req;
    assign mem_wr    = resetn & (w_grant_data ? data_sram_wr : inst_sram_wr);
    assign mem_size  = resetn ? (w_grant_data ? data_sram_size  : inst_sram_size)  : 2'd0;
    assign mem_addr  = resetn ? (w_grant_data ? data_sram_addr  : inst_sram_addr)  : 32'd0;
    assign mem_wstrb = resetn ? (w_grant_data ? data_sram_wstrb : inst_sram_wstrb) : 4'd0;
    assign mem_wdata = resetn ? (w_grant_data ? data_sram_wdata : inst_sram_wdata) : 32'd0;

    assign inst_sram_addr_ok = w_push & ~w_grant_data;
    assign data_sram_addr_ok = w_push &  w_grant_data;
    assign inst_sram_data_ok = w_pop  & ~w_head;
    assign data_sram_data_ok = w_pop  &  w_head;
    assign inst_sram_rdata   = resetn ? mem_rdata : 32'd0;
    assign data_sram_rdata   = resetn ? mem_rdata : 32'd0;
    assign err_orphan_resp   = resetn & r_err;

endmodule
